draw_rect_array: RTL

Parametrised rectangle-overlay stage for the VGA pixel pipeline. Sits between the background stage and the mouse overlay, in place of the single-rectangle stage. Draws up to N_RECT independently configured rectangles over the incoming pixel stream, with fixed priority. Configuration goes into shadow registers and is committed tear-free at the start of vertical blanking.

---
 rtl/draw_rect_array.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/draw_rect_array.sv
// Rectangle overlay stage: up to N_RECT prioritised filled rectangles over the
// pixel stream, with a shadow config bank committed at the rising edge of vblnk.
module draw_rect_array #(
  parameter int N_RECT = 4,
  parameter int IDX_W  = 2,
  parameter int CW     = 11
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CW-1:0]    hcount_in,
  input  logic [CW-1:0]    vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [3:0]       r_in,
  input  logic [3:0]       g_in,
  input  logic [3:0]       b_in,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [CW-1:0]    cfg_x,
  input  logic [CW-1:0]    cfg_y,
  input  logic [CW-1:0]    cfg_w,
  input  logic [CW-1:0]    cfg_h,
  input  logic [11:0]      cfg_rgb,
  output logic             cfg_pending,
  output logic             frame_tick,
  output logic [CW-1:0]    hcount_out,
  output logic [CW-1:0]    vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [3:0]       r_out,
  output logic [3:0]       g_out,
  output logic [3:0]       b_out
);

  localparam logic [IDX_W:0] N_RECT_LIM = (IDX_W + 1)'(N_RECT);

  logic              vblnk_prev_reg;
  logic              commit;
  logic              wr_ok;
  logic [N_RECT-1:0] hit_next;
  logic [N_RECT-1:0] hit_s1_reg;
  logic [11:0]       slot_rgb [N_RECT];

  logic [CW-1:0] hcount_s1_reg, vcount_s1_reg;
  logic          hsync_s1_reg, vsync_s1_reg, hblnk_s1_reg, vblnk_s1_reg;
  logic [11:0]   bg_s1_reg;
  logic [11:0]   rgb_next;

  assign commit = vblnk_in && !vblnk_prev_reg;
  assign wr_ok  = cfg_wr && ({1'b0, cfg_idx} < N_RECT_LIM);

  // Per-slot shadow/active banks and hit test against the active bank.
  for (genvar gi = 0; gi < N_RECT; gi++) begin : g_slot
    logic          en_sh_reg, en_act_reg;
    logic [CW-1:0] x_sh_reg, y_sh_reg, w_sh_reg, h_sh_reg;
    logic [CW-1:0] x_act_reg, y_act_reg, w_act_reg, h_act_reg;
    logic [11:0]   rgb_sh_reg, rgb_act_reg, rgb_s1_reg;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        en_sh_reg   <= 1'b0;
        x_sh_reg    <= '0;
        y_sh_reg    <= '0;
        w_sh_reg    <= '0;
        h_sh_reg    <= '0;
        rgb_sh_reg  <= '0;
        en_act_reg  <= 1'b0;
        x_act_reg   <= '0;
        y_act_reg   <= '0;
        w_act_reg   <= '0;
        h_act_reg   <= '0;
        rgb_act_reg <= '0;
        rgb_s1_reg  <= '0;
      end else begin
        // Non-blocking copy takes the shadow as it stood before a same-cycle write.
        if (commit) begin
          en_act_reg  <= en_sh_reg;
          x_act_reg   <= x_sh_reg;
          y_act_reg   <= y_sh_reg;
          w_act_reg   <= w_sh_reg;
          h_act_reg   <= h_sh_reg;
          rgb_act_reg <= rgb_sh_reg;
        end
        if (wr_ok && cfg_idx == IDX_W'(gi)) begin
          en_sh_reg  <= cfg_en;
          x_sh_reg   <= cfg_x;
          y_sh_reg   <= cfg_y;
          w_sh_reg   <= cfg_w;
          h_sh_reg   <= cfg_h;
          rgb_sh_reg <= cfg_rgb;
        end
        // Colour travels with its hit bit so a commit cannot tear a pixel in flight.
        rgb_s1_reg <= rgb_act_reg;
      end
    end

    assign hit_next[gi] = en_act_reg
        && ({1'b0, hcount_in} >= {1'b0, x_act_reg})
        && ({1'b0, hcount_in} <  ({1'b0, x_act_reg} + {1'b0, w_act_reg}))
        && ({1'b0, vcount_in} >= {1'b0, y_act_reg})
        && ({1'b0, vcount_in} <  ({1'b0, y_act_reg} + {1'b0, h_act_reg}));

    assign slot_rgb[gi] = rgb_s1_reg;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      vblnk_prev_reg <= 1'b1;
      cfg_pending    <= 1'b0;
      frame_tick     <= 1'b0;
    end else begin
      vblnk_prev_reg <= vblnk_in;
      frame_tick     <= commit;
      if (wr_ok)
        cfg_pending <= 1'b1;
      else if (commit)
        cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_s1_reg <= '0;
      vcount_s1_reg <= '0;
      hsync_s1_reg  <= 1'b0;
      vsync_s1_reg  <= 1'b0;
      hblnk_s1_reg  <= 1'b0;
      vblnk_s1_reg  <= 1'b0;
      bg_s1_reg     <= '0;
      hit_s1_reg    <= '0;
    end else begin
      hcount_s1_reg <= hcount_in;
      vcount_s1_reg <= vcount_in;
      hsync_s1_reg  <= hsync_in;
      vsync_s1_reg  <= vsync_in;
      hblnk_s1_reg  <= hblnk_in;
      vblnk_s1_reg  <= vblnk_in;
      bg_s1_reg     <= {r_in, g_in, b_in};
      hit_s1_reg    <= hit_next;
    end
  end

  // Walk from the highest slot down so the lowest hitting index wins.
  always_comb begin
    rgb_next = bg_s1_reg;
    for (int i = N_RECT - 1; i >= 0; i--)
      if (hit_s1_reg[i]) rgb_next = slot_rgb[i];
    if (hblnk_s1_reg || vblnk_s1_reg) rgb_next = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
    end else begin
      hcount_out <= hcount_s1_reg;
      vcount_out <= vcount_s1_reg;
      hsync_out  <= hsync_s1_reg;
      vsync_out  <= vsync_s1_reg;
      hblnk_out  <= hblnk_s1_reg;
      vblnk_out  <= vblnk_s1_reg;
      r_out      <= rgb_next[11:8];
      g_out      <= rgb_next[7:4];
      b_out      <= rgb_next[3:0];
    end
  end

endmodule
